// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per CALC cycle, sign fix-up in FIX, result held in DONE.
module iter_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   divisor;
  logic [XLEN-1:0]   result;
  logic [1:0]        op;
  logic              sign_a;
  logic              sign_b;

  logic              accept;
  logic              is_signed;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic              div_zero;
  logic              overflow;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  assign accept    = in_valid & (state == StIdle);
  assign is_signed = ~in_op[0];
  assign a_neg     = is_signed & in_a[XLEN-1];
  assign b_neg     = is_signed & in_b[XLEN-1];
  assign abs_a     = a_neg ? (~in_a + 1'b1) : in_a;
  assign abs_b     = b_neg ? (~in_b + 1'b1) : in_b;
  assign div_zero  = (in_b == '0);
  assign overflow  = is_signed & (in_a == {1'b1, {(XLEN-1){1'b0}}}) & (&in_b);

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = in_op[1] ? in_a : '1;
    end else begin
      special_res = in_op[1] ? '0 : in_a;
    end
  end

  // Trial subtraction at XLEN+1 bits; diff MSB set means the subtraction underflowed.
  assign rem_sh  = {rem, quo[XLEN-1]};
  assign diff    = rem_sh - {1'b0, divisor};
  assign quo_fix = (sign_a ^ sign_b) ? (~quo + 1'b1) : quo;
  assign rem_fix = sign_a ? (~rem + 1'b1) : rem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= StIdle;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      result  <= '0;
      op      <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
    end else if (flush) begin
      state <= StIdle;
    end else begin
      unique case (state)
        StIdle: begin
          if (accept) begin
            op      <= in_op;
            sign_a  <= a_neg;
            sign_b  <= b_neg;
            rem     <= '0;
            quo     <= abs_a;
            divisor <= abs_b;
            cnt     <= CNT_W'(XLEN);
            if (div_zero || overflow) begin
              result <= special_res;
              state  <= StDone;
            end else begin
              state <= StCalc;
            end
          end
        end
        StCalc: begin
          if (!diff[XLEN]) begin
            rem <= diff[XLEN-1:0];
          end else begin
            rem <= rem_sh[XLEN-1:0];
          end
          quo <= {quo[XLEN-2:0], ~diff[XLEN]};
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= StFix;
          end
        end
        StFix: begin
          result <= op[1] ? rem_fix : quo_fix;
          state  <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign in_ready   = (state == StIdle);
  assign out_valid  = (state == StDone);
  assign busy       = (state != StIdle);
  assign out_result = result;

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the execute stage beside the single-cycle ALU adder. It is the "inverse" arithmetic unit: it produces one quotient bit per cycle by trial subtraction.
- Decoupled valid/ready interfaces on both sides let the issue logic stall while it is busy.

Parameters:
- XLEN, 32, operand/result width (power of two, >= 8).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  pipeline kill; aborts any operation in progress.
- in_valid  input  1  request valid.
- in_ready  output  1  divider can accept a request (IDLE state).
- in_op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- in_a  input  XLEN  dividend.
- in_b  input  XLEN  divisor.
- out_valid  output  1  result valid, held until accepted.
- out_ready  input  1  consumer accepts result.
- out_result  output  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU).
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE; counter, partial remainder and quotient registers clear.
  - Outputs: in_ready=1, out_valid=0, out_result=0, busy=0.
  - Reset mid-operation discards the operation; no result is produced.
- Priority per edge: reset > flush > handshake/state advance.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - Accept happens when in_valid & in_ready & ~flush.
  - On accept, latch in_op. For signed ops (op[0]=0), latch |in_a| and |in_b| plus the sign flags. Unsigned ops latch raw operands.
  - Special cases go directly to DONE with the result computed in that cycle:
    - in_b==0: DIV/DIVU -> all ones; REM/REMU -> in_a.
    - Signed overflow (in_a==1<<(XLEN-1), in_b==all ones, op DIV/REM): DIV -> in_a; REM -> 0.
  - All other requests go to CALC with counter=XLEN.
- CALC:
  - Each cycle: shift {rem,quo} left by one, bringing in the dividend MSB.
  - Trial subtraction: diff = rem_shifted - divisor, computed at XLEN+1 bits.
  - If diff is non-negative: rem=diff and the quotient LSB is 1. Otherwise rem is unchanged and the LSB is 0.
  - Counter decrements. After exactly XLEN CALC cycles, go to FIX.
- FIX (1 cycle):
  - Signed quotient is negated if sign(a)^sign(b).
  - Signed remainder is negated if sign(a). The remainder takes the dividend's sign.
  - Select quotient or remainder by op[1] and register it into out_result. Go to DONE.
- DONE:
  - out_valid=1 and out_result stable until out_valid & out_ready, then go to IDLE.
  - in_ready=0 in DONE, so there is a mandatory one-cycle bubble before the next accept.
- Latency, counted from the accept edge:
  - Normal ops: out_valid first high XLEN+2 cycles later (34 for XLEN=32).
  - Special cases: out_valid high in the cycle immediately after accept.
- flush:
  - In any state: next state IDLE, out_valid=0 next cycle, no result emitted.
  - In IDLE with in_valid=1: no accept.
  - In DONE with out_ready=1 in the same cycle: the result is dropped anyway (consumer must qualify with its own flush).
- in_a/in_b/in_op are ignored outside the accept cycle. Changing them mid-operation has no effect.
- busy = (state != IDLE).
- No combinational path from inputs to out_valid/out_result. in_ready depends on state only.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-CALC -> next cycle in_ready=1, busy=0, out_valid=0, out_result=0; no result ever appears.
- DIVU a=100, b=7 -> out_valid exactly 34 cycles after accept, out_result=14. Repeat as REMU -> out_result=2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). REM a=7, b=-2 -> 1.
- Divide by zero: DIV a=5, b=0 -> 0xFFFFFFFF one cycle after accept. REMU a=0x12345678, b=0 -> 0x12345678.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM same operands -> 0, single-cycle path.
- Handshake/flush:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_result stable, in_ready=0.
  - Assert flush at CALC cycle 10 -> IDLE next cycle, no out_valid.
  - New DIVU 9/3 accepted afterwards -> 3.
